// File: rtl/fifo_prog_pkg.sv
// Types and helpers for fifo_prog: per-cycle operation encoding and almost-full decode.
package fifo_prog_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // A margin of DEPTH or more would underflow the subtraction, so it pins the flag high.
  function automatic logic af_hit(input int unsigned count, input int unsigned depth,
                                  input int unsigned margin);
    if (margin >= depth) return 1'b1;
    return count >= (depth - margin);
  endfunction

endpackage

// File: rtl/fifo_defs.vh
// Shared constants for the fifo family: read-mode selectors and depth from address width.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH
`define FIFO_STD 0
`define FIFO_FWFT 1
`define FIFO_DEPTH(bw) (1 << (bw))
`endif

// File: rtl/fifo_mem.sv
// Unreset FIFO storage: one synchronous write port, one asynchronous read port.
`include "fifo_defs.vh"
module fifo_mem #(
  parameter int BUF_WIDTH  = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [BUF_WIDTH-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [BUF_WIDTH-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = `FIFO_DEPTH(BUF_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_prog.sv
// Programmable-threshold FIFO with sticky error flags and selectable registered or FWFT read.
`include "fifo_defs.vh"
module fifo_prog
  import fifo_prog_pkg::*;
#(
  parameter int BUF_WIDTH  = 4,
  parameter int DATA_WIDTH = 4,
  parameter int FWFT       = `FIFO_STD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic [BUF_WIDTH:0]    uH,
  input  logic [BUF_WIDTH:0]    uL,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  valid,
  output logic [BUF_WIDTH:0]    fifo_counter,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = `FIFO_DEPTH(BUF_WIDTH);
  localparam int CW    = BUF_WIDTH + 1;
  localparam int PW    = BUF_WIDTH;
  localparam logic [BUF_WIDTH:0]   LP_DEPTH   = CW'(DEPTH);
  localparam logic [BUF_WIDTH:0]   LP_CNT_ONE = CW'(1);
  localparam logic [BUF_WIDTH-1:0] LP_PTR_ONE = PW'(1);

  logic [BUF_WIDTH:0]    r_count;
  logic [BUF_WIDTH-1:0]  r_wr_ptr;
  logic [BUF_WIDTH-1:0]  r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  fifo_op_e              w_op;

  assign buf_empty    = (r_count == '0);
  assign buf_full     = (r_count == LP_DEPTH);
  assign almost_empty = (r_count <= uL);
  assign almost_full  = af_hit(32'(r_count), DEPTH, 32'(uH));

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign w_rd_acc = rd_en && !buf_empty;
  assign w_wr_acc = wr_en && (!buf_full || w_rd_acc);
  assign w_op     = fifo_op_e'({w_wr_acc, w_rd_acc});
  // Storage has no reset, so block writes while reset is held.
  assign w_mem_we = w_wr_acc && !rst;

  fifo_mem #(
    .BUF_WIDTH  (BUF_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (buf_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (w_op)
        OP_WR:   r_count <= r_count + LP_CNT_ONE;
        OP_RD:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      if (err_clr) r_overflow <= 1'b0;
      else if (wr_en && !w_wr_acc) r_overflow <= 1'b1;
      if (err_clr) r_underflow <= 1'b0;
      else if (rd_en && buf_empty) r_underflow <= 1'b1;
    end
  end

  assign fifo_counter = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  generate
    if (FWFT == `FIFO_FWFT) begin : gen_fwft
      assign buf_out = buf_empty ? '0 : w_mem_rdata;
      assign valid   = !buf_empty;
    end else begin : gen_std
      logic [DATA_WIDTH-1:0] r_buf_out;
      logic                  r_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_buf_out <= '0;
          r_valid   <= 1'b0;
        end else begin
          r_valid <= w_rd_acc;
          if (w_rd_acc) r_buf_out <= w_mem_rdata;
        end
      end

      assign buf_out = r_buf_out;
      assign valid   = r_valid;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_prog.sv
// Directed self-checking bench for fifo_prog: registered-read and FWFT instances on shared stimulus.
module tb_fifo_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, err_clr;
  logic [3:0] buf_in;
  logic [4:0] uH, uL;

  logic [3:0] s_out, f_out;
  logic       s_valid, f_valid;
  logic [4:0] s_cnt, f_cnt;
  logic       s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic       f_empty, f_full, f_ae, f_af, f_ovf, f_unf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_prog #(.BUF_WIDTH(4), .DATA_WIDTH(4), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .buf_in(buf_in),
    .uH(uH), .uL(uL), .err_clr(err_clr), .buf_out(s_out), .valid(s_valid),
    .fifo_counter(s_cnt), .buf_empty(s_empty), .buf_full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_prog #(.BUF_WIDTH(4), .DATA_WIDTH(4), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .buf_in(buf_in),
    .uH(uH), .uL(uL), .err_clr(err_clr), .buf_out(f_out), .valid(f_valid),
    .fifo_counter(f_cnt), .buf_empty(f_empty), .buf_full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .overflow(f_ovf), .underflow(f_unf)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic [3:0] din;
    logic       clr;
    logic [4:0] exp_cnt;
    logic [3:0] exp_out;
    logic       exp_vld;
    logic       exp_emp;
    logic       exp_unf;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic wr, input logic rd, input logic [3:0] din, input logic clr);
    wr_en = wr; rd_en = rd; buf_in = din; err_clr = clr;
    @(posedge clk);
    #1;
    $display("[%0t] wr=%0b rd=%0b din=%0h clr=%0b -> cnt=%0d out=%0h vld=%0b ovf=%0b unf=%0b",
             $time, wr, rd, din, clr, s_cnt, s_out, s_valid, s_ovf, s_unf);
  endtask

  logic [3:0] q [$];
  logic [3:0] exp_d;
  logic       do_wr, do_rd;

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; err_clr = 0; buf_in = 0; uH = 5'd2; uL = 5'd3;
    #12;
    chk("rst_cnt", s_cnt, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_ae", s_ae, 1);
    chk("rst_af", s_af, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_out", s_out, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_unf", s_unf, 0);
    chk("rst_fwft_valid", f_valid, 0);
    rst = 1'b0;

    // wr rd din clr | cnt out vld emp unf
    tbl[0] = '{1'b0, 1'b1, 4'h0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 4'h9, 1'b0, 5'd1, 4'h0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd1, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 4'h3, 1'b0, 5'd2, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 4'h0, 1'b0, 5'd1, 4'h9, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd1, 4'h9, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 4'h5, 1'b0, 5'd1, 4'h3, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 4'h0, 1'b0, 5'd0, 4'h5, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 4'h5, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].clr);
      chk($sformatf("tbl%0d_cnt", i), s_cnt, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_out", i), s_out, tbl[i].exp_out);
      chk($sformatf("tbl%0d_vld", i), s_valid, tbl[i].exp_vld);
      chk($sformatf("tbl%0d_emp", i), s_empty, tbl[i].exp_emp);
      chk($sformatf("tbl%0d_unf", i), s_unf, tbl[i].exp_unf);
    end

    // Fill 0..15 with threshold tracking.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'(i), 1'b0);
      chk($sformatf("fill%0d_cnt", i), s_cnt, i + 1);
      chk($sformatf("fill%0d_af", i), s_af, (i + 1) >= 14);
      chk($sformatf("fill%0d_ae", i), s_ae, (i + 1) <= 3);
      chk($sformatf("fill%0d_full", i), s_full, (i + 1) == 16);
      if (i == 13) begin
        uH = 5'd0; #1;
        chk("af_uh0_at14", s_af, 0);
        uH = 5'd2; #1;
        chk("af_uh2_at14", s_af, 1);
      end
    end

    step(1'b1, 1'b0, 4'hF, 1'b0);
    chk("ovf_cnt", s_cnt, 16);
    chk("ovf_set", s_ovf, 1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("ovf_clr", s_ovf, 0);

    // Pass-through on full: A goes in behind the 15 remaining words.
    step(1'b1, 1'b1, 4'hA, 1'b0);
    chk("pt_cnt", s_cnt, 16);
    chk("pt_ovf", s_ovf, 0);
    chk("pt_out", s_out, 0);
    chk("pt_vld", s_valid, 1);
    for (int k = 1; k < 16; k++) begin
      step(1'b0, 1'b1, 4'h0, 1'b0);
      chk($sformatf("drain%0d_out", k), s_out, k);
      chk($sformatf("drain%0d_cnt", k), s_cnt, 16 - k);
    end
    step(1'b0, 1'b1, 4'h0, 1'b0);
    chk("drain_last_out", s_out, 4'hA);
    chk("drain_empty", s_empty, 1);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk("drain_vld_low", s_valid, 0);
    chk("fwft_empty_out", f_out, 0);
    chk("fwft_empty_vld", f_valid, 0);

    // FWFT head visibility and pop.
    step(1'b1, 1'b0, 4'h5, 1'b0);
    chk("fwft_w5_out", f_out, 5);
    chk("fwft_w5_vld", f_valid, 1);
    chk("std_w5_vld", s_valid, 0);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    chk("fwft_pop_vld", f_valid, 0);
    chk("fwft_pop_out", f_out, 0);
    step(1'b1, 1'b0, 4'h7, 1'b0);
    step(1'b1, 1'b0, 4'h8, 1'b0);
    chk("fwft_head7", f_out, 7);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    chk("fwft_head8", f_out, 8);
    chk("fwft_head8_vld", f_valid, 1);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    chk("fwft_drained_vld", f_valid, 0);

    uH = 5'd20; #1;
    chk("af_saturate", s_af, 1);
    uH = 5'd2; #1;
    chk("af_restore", s_af, 0);

    // 40 interleaved ops; ~30 writes wrap both pointers twice.
    for (int i = 0; i < 40; i++) begin
      do_wr = (i % 4) != 3;
      do_rd = (i % 4) != 0;
      exp_d = 4'h0;
      if (do_rd) exp_d = q.pop_front();
      if (do_wr) q.push_back(4'((i * 7 + 3) & 15));
      step(do_wr, do_rd, 4'((i * 7 + 3) & 15), 1'b0);
      if (do_rd) chk($sformatf("wrap%0d_out", i), s_out, exp_d);
      chk($sformatf("wrap%0d_cnt", i), s_cnt, q.size());
    end

    // Async reset mid-stream.
    step(1'b1, 1'b0, 4'h1, 1'b0);
    step(1'b1, 1'b0, 4'h2, 1'b0);
    step(1'b1, 1'b0, 4'h3, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    chk("pre_rst_out", s_out, 1);
    chk("pre_rst_vld", s_valid, 1);
    wr_en = 0; rd_en = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", s_cnt, 0);
    chk("arst_empty", s_empty, 1);
    chk("arst_vld", s_valid, 0);
    chk("arst_out", s_out, 0);
    chk("arst_fwft_vld", f_valid, 0);
    step(1'b1, 1'b0, 4'h9, 1'b0);
    chk("rst_held_wr_cnt", s_cnt, 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk("post_rst_cnt", s_cnt, 0);
    step(1'b1, 1'b0, 4'h4, 1'b0);
    chk("post_rst_fwft_out", f_out, 4);
    chk("post_rst_cnt1", s_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
